npu_mac_sched: RTL

Loop sequencer for the NPU MAC datapath. It latches the tensor configuration published on the CSR bus when software writes the control bit. It then walks the output tensor (T2) and the kernel window over input T0 and weights T1, issuing one operand-address beat per MAC. It also issues one write-back command per output element and drives the CSR status bit while active. It sits between the CSR register file (Slave side of the CSR bus) and the MAC/memory datapath.

---
 rtl/npu_mac_sched_if.sv | 47 ++++
 rtl/npu_mac_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/npu_mac_sched_if.sv
// CSR, operand and write-back signals of the NPU MAC loop sequencer.
// The master modport is the sequencer; the slave modport is the CSR file / datapath side.
interface npu_mac_sched_if #(
    parameter int A_W = 32
);
    logic           start_i;
    logic           busy_o;
    logic [A_W-1:0] a0_i;
    logic [A_W-1:0] a1_i;
    logic [A_W-1:0] a2_i;
    logic [9:0]     t0_h_i;
    logic [9:0]     t0_w_i;
    logic [5:0]     t0_c_i;
    logic [4:0]     t1_h_i;
    logic [4:0]     t1_w_i;
    logic [5:0]     t1_c_i;
    logic [9:0]     t2_h_i;
    logic [9:0]     t2_w_i;
    logic [10:0]    t2_d_i;
    logic           op_valid_o;
    logic           op_ready_i;
    logic [A_W-1:0] op_addr0_o;
    logic [A_W-1:0] op_addr1_o;
    logic           op_first_o;
    logic           op_last_o;
    logic           wr_valid_o;
    logic           wr_ready_i;
    logic [A_W-1:0] wr_addr_o;
    logic           done_o;
    logic           err_o;

    modport master (
        input  start_i, a0_i, a1_i, a2_i,
        input  t0_h_i, t0_w_i, t0_c_i, t1_h_i, t1_w_i, t1_c_i, t2_h_i, t2_w_i, t2_d_i,
        input  op_ready_i, wr_ready_i,
        output busy_o, op_valid_o, op_addr0_o, op_addr1_o, op_first_o, op_last_o,
        output wr_valid_o, wr_addr_o, done_o, err_o
    );

    modport slave (
        output start_i, a0_i, a1_i, a2_i,
        output t0_h_i, t0_w_i, t0_c_i, t1_h_i, t1_w_i, t1_c_i, t2_h_i, t2_w_i, t2_d_i,
        output op_ready_i, wr_ready_i,
        input  busy_o, op_valid_o, op_addr0_o, op_addr1_o, op_first_o, op_last_o,
        input  wr_valid_o, wr_addr_o, done_o, err_o
    );
endinterface

// File: rtl/npu_mac_sched.sv
// Loop sequencer for the NPU MAC datapath: walks output tensor and kernel window,
// emitting one operand-address beat per MAC and one write-back per output element.
module npu_mac_sched #(
    parameter int A_W = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    npu_mac_sched_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]     r_state;
    logic           r_err;
    logic [A_W-1:0] r_a0, r_a1, r_a2;
    logic [9:0]     r_t0h, r_t0w, r_t2h, r_t2w;
    logic [5:0]     r_t0c, r_t1c;
    logic [4:0]     r_t1h, r_t1w;
    logic [10:0]    r_t2d;

    logic [A_W-1:0] r_stride;
    logic [A_W-1:0] r_addr0, r_row0, r_win0, r_line0;
    logic [A_W-1:0] r_addr1, r_waddr;
    logic [9:0]     r_oh, r_ow;
    logic [10:0]    r_od;
    logic [4:0]     r_kh, r_kw;
    logic [5:0]     r_c;

    logic [15:0]    w_stride16;
    logic [A_W-1:0] w_stride, w_cext, w_next_win, w_next_line;
    logic           w_cfg_bad;
    logic           w_c_end, w_kw_end, w_kh_end, w_last;
    logic           w_od_end, w_ow_end, w_oh_end;
    logic           w_op_fire, w_wr_fire;

    // Byte distance between consecutive T0 rows, and between horizontally adjacent windows.
    assign w_stride16  = {6'd0, r_t0w} * {10'd0, r_t0c};
    assign w_stride    = A_W'(w_stride16);
    assign w_cext      = A_W'(r_t0c);
    assign w_next_win  = r_win0 + w_cext;
    assign w_next_line = r_line0 + r_stride;

    assign w_cfg_bad = (r_t0h == 10'd0) || (r_t0w == 10'd0) || (r_t0c == 6'd0) ||
                       (r_t1h == 5'd0)  || (r_t1w == 5'd0)  || (r_t1c == 6'd0) ||
                       (r_t2h == 10'd0) || (r_t2w == 10'd0) || (r_t2d == 11'd0) ||
                       (r_t1c != r_t0c) ||
                       (({2'b00, r_t2h} + {7'd0, r_t1h}) > ({2'b00, r_t0h} + 12'd1)) ||
                       (({2'b00, r_t2w} + {7'd0, r_t1w}) > ({2'b00, r_t0w} + 12'd1));

    assign w_c_end  = (r_c  == r_t0c - 6'd1);
    assign w_kw_end = (r_kw == r_t1w - 5'd1);
    assign w_kh_end = (r_kh == r_t1h - 5'd1);
    assign w_last   = w_c_end && w_kw_end && w_kh_end;
    assign w_od_end = (r_od == r_t2d - 11'd1);
    assign w_ow_end = (r_ow == r_t2w - 10'd1);
    assign w_oh_end = (r_oh == r_t2h - 10'd1);

    assign w_op_fire = (r_state == S_RUN) && bus.op_ready_i;
    assign w_wr_fire = (r_state == S_WB) && bus.wr_ready_i;

    assign bus.busy_o     = (r_state != S_IDLE);
    assign bus.op_valid_o = (r_state == S_RUN);
    assign bus.op_first_o = (r_state == S_RUN) && (r_kh == 5'd0) && (r_kw == 5'd0) && (r_c == 6'd0);
    assign bus.op_last_o  = (r_state == S_RUN) && w_last;
    assign bus.op_addr0_o = r_addr0;
    assign bus.op_addr1_o = r_addr1;
    assign bus.wr_valid_o = (r_state == S_WB);
    assign bus.wr_addr_o  = r_waddr;
    assign bus.done_o     = (r_state == S_DONE) || (r_state == S_ERR);
    assign bus.err_o      = r_err;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
            r_a0    <= '0;
            r_a1    <= '0;
            r_a2    <= '0;
            r_t0h   <= '0;
            r_t0w   <= '0;
            r_t0c   <= '0;
            r_t1h   <= '0;
            r_t1w   <= '0;
            r_t1c   <= '0;
            r_t2h   <= '0;
            r_t2w   <= '0;
            r_t2d   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_a0    <= bus.a0_i;
                        r_a1    <= bus.a1_i;
                        r_a2    <= bus.a2_i;
                        r_t0h   <= bus.t0_h_i;
                        r_t0w   <= bus.t0_w_i;
                        r_t0c   <= bus.t0_c_i;
                        r_t1h   <= bus.t1_h_i;
                        r_t1w   <= bus.t1_w_i;
                        r_t1c   <= bus.t1_c_i;
                        r_t2h   <= bus.t2_h_i;
                        r_t2w   <= bus.t2_w_i;
                        r_t2d   <= bus.t2_d_i;
                        r_err   <= 1'b0;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_cfg_bad) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN:   if (w_op_fire && w_last) r_state <= S_WB;
                S_WB: begin
                    if (w_wr_fire)
                        r_state <= (w_od_end && w_ow_end && w_oh_end) ? S_DONE : S_RUN;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Running pointers: within one kernel row T0 bytes are contiguous, and the whole
    // T1 walk and the T2 write-back walk are contiguous, so only row/window jumps need adds.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_stride <= '0;
            r_addr0  <= '0;
            r_row0   <= '0;
            r_win0   <= '0;
            r_line0  <= '0;
            r_addr1  <= '0;
            r_waddr  <= '0;
            r_oh     <= '0;
            r_ow     <= '0;
            r_od     <= '0;
            r_kh     <= '0;
            r_kw     <= '0;
            r_c      <= '0;
        end else begin
            case (r_state)
                S_CHECK: begin
                    r_stride <= w_stride;
                    r_addr0  <= r_a0;
                    r_row0   <= r_a0;
                    r_win0   <= r_a0;
                    r_line0  <= r_a0;
                    r_addr1  <= r_a1;
                    r_waddr  <= r_a2;
                    r_oh     <= '0;
                    r_ow     <= '0;
                    r_od     <= '0;
                    r_kh     <= '0;
                    r_kw     <= '0;
                    r_c      <= '0;
                end
                S_RUN: begin
                    if (w_op_fire) begin
                        r_addr1 <= r_addr1 + A_W'(1);
                        if (!w_c_end) begin
                            r_c     <= r_c + 6'd1;
                            r_addr0 <= r_addr0 + A_W'(1);
                        end else if (!w_kw_end) begin
                            r_c     <= '0;
                            r_kw    <= r_kw + 5'd1;
                            r_addr0 <= r_addr0 + A_W'(1);
                        end else if (!w_kh_end) begin
                            r_c     <= '0;
                            r_kw    <= '0;
                            r_kh    <= r_kh + 5'd1;
                            r_row0  <= r_row0 + r_stride;
                            r_addr0 <= r_row0 + r_stride;
                        end else begin
                            r_c     <= '0;
                            r_kw    <= '0;
                            r_kh    <= '0;
                        end
                    end
                end
                S_WB: begin
                    if (w_wr_fire) begin
                        r_waddr <= r_waddr + A_W'(1);
                        if (!w_od_end) begin
                            r_od    <= r_od + 11'd1;
                            r_row0  <= r_win0;
                            r_addr0 <= r_win0;
                        end else if (!w_ow_end) begin
                            r_od    <= '0;
                            r_ow    <= r_ow + 10'd1;
                            r_win0  <= w_next_win;
                            r_row0  <= w_next_win;
                            r_addr0 <= w_next_win;
                            r_addr1 <= r_a1;
                        end else if (!w_oh_end) begin
                            r_od    <= '0;
                            r_ow    <= '0;
                            r_oh    <= r_oh + 10'd1;
                            r_line0 <= w_next_line;
                            r_win0  <= w_next_line;
                            r_row0  <= w_next_line;
                            r_addr0 <= w_next_line;
                            r_addr1 <= r_a1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
